seq_detector_param: RTL and testbench

- Parametrised serial bit-pattern detector. Generalises the fixed-pattern Moore sequence FSM.
- Adds run-time programmable pattern, configurable pattern width, selectable overlap/non-overlap mode, input-valid qualification, and a saturating match counter.
- Sits on a serial bit stream and flags each occurrence of the programmed pattern to downstream logic.

---
 rtl/seq_det_pkg.sv | 24 ++
 rtl/sat_counter.sv | 20 ++
 rtl/seq_detector_param.sv | 97 +++++++++
 tb/tb_seq_detector_param.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_det_pkg.sv
// Shared definitions for the serial pattern detector: control states, mode
// constants and the width helper used to size the fill counter.
package seq_det_pkg;

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    FILLING = 2'd1,
    ARMED   = 2'd2
  } ctl_state_e;

  localparam logic OVERLAP     = 1'b1;
  localparam logic NON_OVERLAP = 1'b0;

  // Ceiling log2; callers pass n >= 2 so the result is never zero.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int unsigned p = 1; p < n; p = p << 1) begin
      r++;
    end
    return r;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear has priority over inc.
module sat_counter #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/seq_detector_param.sv
// Programmable serial bit-pattern detector with overlap control, valid
// qualification and a saturating match counter.
module seq_detector_param
  import seq_det_pkg::*;
#(
  parameter int unsigned           PATTERN_W     = 4,
  parameter int unsigned           CNT_W         = 8,
  parameter logic [PATTERN_W-1:0]  RESET_PATTERN = 4'b1011
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               inp,
  input  logic                               inp_valid,
  input  logic                               load,
  input  logic [PATTERN_W-1:0]               pat_in,
  input  logic                               overlap,
  input  logic                               clear_count,
  output logic                               outp,
  output logic [CNT_W-1:0]                   match_count,
  output logic [clog2(PATTERN_W+1)-1:0]      fill
);

  localparam int unsigned FILL_W = clog2(PATTERN_W + 1);

  ctl_state_e           state_q, state_d;
  logic [PATTERN_W-1:0] pattern_q, pattern_d;
  logic [PATTERN_W-1:0] history_q, history_d;
  logic [PATTERN_W-1:0] hist_shift;
  logic [FILL_W-1:0]    fill_q, fill_d, fill_inc;
  logic                 outp_d;
  logic                 full;
  logic                 hit;

  always_ff @(posedge clk) begin
    if (rst) begin
      pattern_q <= RESET_PATTERN;
      history_q <= '0;
      fill_q    <= '0;
      state_q   <= EMPTY;
      outp      <= 1'b0;
    end else begin
      pattern_q <= pattern_d;
      history_q <= history_d;
      fill_q    <= fill_d;
      state_q   <= state_d;
      outp      <= outp_d;
    end
  end

  always_comb begin
    // Truncating cast keeps the newest PATTERN_W bits, which also covers PATTERN_W=1.
    hist_shift = PATTERN_W'({history_q, inp});
    full       = (state_q == ARMED);
    fill_inc   = full ? fill_q : fill_q + FILL_W'(1);
    hit        = inp_valid & ~load & (fill_inc == FILL_W'(PATTERN_W))
                 & (hist_shift == pattern_q);

    pattern_d = pattern_q;
    history_d = history_q;
    fill_d    = fill_q;
    state_d   = state_q;
    outp_d    = 1'b0;

    if (load) begin
      pattern_d = pat_in;
      history_d = '0;
      fill_d    = '0;
      state_d   = EMPTY;
    end else if (inp_valid) begin
      history_d = hist_shift;
      fill_d    = fill_inc;
      outp_d    = hit;
      unique case (state_q)
        EMPTY, FILLING: state_d = (fill_inc == FILL_W'(PATTERN_W)) ? ARMED : FILLING;
        ARMED:          state_d = ARMED;
        default:        state_d = EMPTY;
      endcase
      if (hit && (overlap == NON_OVERLAP)) begin
        fill_d  = '0;
        state_d = EMPTY;
      end
    end
  end

  assign fill = fill_q;

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_match_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (hit),
    .clr   (clear_count),
    .count (match_count)
  );

endmodule

// File: tb/tb_seq_detector_param.sv
// Self-checking bench for seq_detector_param: directed scenarios plus a
// randomized run against a queue-based reference model.
module tb_seq_detector_param;

  localparam int          PW      = 4;
  localparam logic [3:0]  RST_PAT = 4'b1011;

  logic       clk = 1'b0;
  logic       rst, inp, inp_valid, load, overlap, clear_count;
  logic [3:0] pat_in;
  logic       outp, outp2;
  logic [7:0] match_count;
  logic [1:0] match_count2;
  logic [2:0] fill, fill2;

  int checks = 0;
  int errors = 0;

  // Reference model: bits received since the last reset/load/non-overlap hit.
  bit         hq[$];
  logic [3:0] m_pat;
  logic       m_outp;
  int         m_cnt8, m_cnt2;

  always #5 clk = ~clk;

  seq_detector_param #(
    .PATTERN_W     (4),
    .CNT_W         (8),
    .RESET_PATTERN (4'b1011)
  ) u_dut (
    .clk (clk), .rst (rst), .inp (inp), .inp_valid (inp_valid), .load (load),
    .pat_in (pat_in), .overlap (overlap), .clear_count (clear_count),
    .outp (outp), .match_count (match_count), .fill (fill)
  );

  seq_detector_param #(
    .PATTERN_W     (4),
    .CNT_W         (2),
    .RESET_PATTERN (4'b1011)
  ) u_dut2 (
    .clk (clk), .rst (rst), .inp (inp), .inp_valid (inp_valid), .load (load),
    .pat_in (pat_in), .overlap (overlap), .clear_count (clear_count),
    .outp (outp2), .match_count (match_count2), .fill (fill2)
  );

  function automatic logic [3:0] last_bits();
    logic [3:0] v;
    v = '0;
    foreach (hq[i]) v = {v[2:0], logic'(hq[i])};
    return v;
  endfunction

  task automatic step(input logic b, input logic v, input logic ld,
                      input logic [3:0] p, input logic cl, input logic r);
    logic hit;
    inp = b; inp_valid = v; load = ld; pat_in = p; clear_count = cl; rst = r;
    @(posedge clk);
    hit = 1'b0;
    if (r) begin
      m_pat = RST_PAT; hq.delete(); m_cnt8 = 0; m_cnt2 = 0;
    end else begin
      if (ld) begin
        m_pat = p; hq.delete();
      end else if (v) begin
        hq.push_back(b);
        if (hq.size() > PW) hq.delete(0);
        if (hq.size() == PW && last_bits() == m_pat) begin
          hit = 1'b1;
          if (!overlap) hq.delete();
        end
      end
      if (cl) begin
        m_cnt8 = 0; m_cnt2 = 0;
      end else if (hit) begin
        if (m_cnt8 < 255) m_cnt8++;
        if (m_cnt2 < 3) m_cnt2++;
      end
    end
    m_outp = hit;
    #1;
  endtask

  task automatic send(input logic b);
    step(b, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b0);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    step(1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b1);
  endtask

  task automatic test_reset();
    overlap = 1'b1;
    step(1'b1, 1'b1, 1'b1, 4'b1111, 1'b1, 1'b1);
    do_reset();
    checks++; if (outp !== 1'b0) begin errors++; $display("FAIL reset_outp got %b exp 0", outp); end
    checks++; if (fill !== 3'd0) begin errors++; $display("FAIL reset_fill got %0d exp 0", fill); end
    checks++; if (match_count !== 8'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", match_count); end
    checks++; if (match_count2 !== 2'd0) begin errors++; $display("FAIL reset_count2 got %0d exp 0", match_count2); end
  endtask

  task automatic test_overlap();
    logic [6:0] s;
    s = 7'b1011011;
    do_reset();
    overlap = 1'b1;
    for (int k = 0; k < 7; k++) begin
      send(s[6-k]);
      checks++;
      if (outp !== ((k == 3) || (k == 6))) begin
        errors++; $display("FAIL ovl_pulse bit%0d got %b exp %b", k + 1, outp, (k == 3) || (k == 6));
      end
    end
    checks++; if (match_count !== 8'd2) begin errors++; $display("FAIL ovl_count got %0d exp 2", match_count); end
    checks++; if (fill !== 3'd4) begin errors++; $display("FAIL ovl_fill got %0d exp 4", fill); end
  endtask

  task automatic test_non_overlap();
    logic [6:0] s;
    s = 7'b1011011;
    do_reset();
    overlap = 1'b0;
    for (int k = 0; k < 7; k++) begin
      send(s[6-k]);
      checks++;
      if (outp !== (k == 3)) begin
        errors++; $display("FAIL novl_pulse bit%0d got %b exp %b", k + 1, outp, k == 3);
      end
    end
    checks++; if (match_count !== 8'd1) begin errors++; $display("FAIL novl_count got %0d exp 1", match_count); end
    checks++; if (fill !== 3'd3) begin errors++; $display("FAIL novl_fill got %0d exp 3", fill); end
  endtask

  task automatic test_idle();
    logic [3:0] s;
    s = 4'b1011;
    do_reset();
    overlap = 1'b1;
    for (int k = 0; k < 4; k++) begin
      send(s[3-k]);
      checks++;
      if (outp !== (k == 3)) begin
        errors++; $display("FAIL idle_bit%0d outp got %b exp %b", k + 1, outp, k == 3);
      end
      for (int j = 0; j < 3; j++) begin
        idle();
        checks++;
        if (outp !== 1'b0 || fill !== 3'(k + 1)) begin
          errors++; $display("FAIL idle_gap%0d outp %b fill %0d exp outp 0 fill %0d", k + 1, outp, fill, k + 1);
        end
      end
    end
    checks++; if (match_count !== 8'd1) begin errors++; $display("FAIL idle_count got %0d exp 1", match_count); end
  endtask

  task automatic test_load();
    logic [6:0] s;
    s = 7'b0110110;
    do_reset();
    overlap = 1'b1;
    send(1'b1); send(1'b0); send(1'b1);
    step(1'b1, 1'b1, 1'b1, 4'b0110, 1'b0, 1'b0);
    checks++;
    if (fill !== 3'd0 || outp !== 1'b0) begin
      errors++; $display("FAIL load_drop fill %0d outp %b exp fill 0 outp 0", fill, outp);
    end
    for (int k = 0; k < 7; k++) begin
      send(s[6-k]);
      checks++;
      if (outp !== ((k == 3) || (k == 6))) begin
        errors++; $display("FAIL load_pulse bit%0d got %b exp %b", k + 1, outp, (k == 3) || (k == 6));
      end
    end
    checks++; if (match_count !== 8'd2) begin errors++; $display("FAIL load_count got %0d exp 2", match_count); end
  endtask

  task automatic test_saturate();
    do_reset();
    overlap = 1'b1;
    step(1'b0, 1'b0, 1'b1, 4'b1111, 1'b0, 1'b0);
    for (int k = 0; k < 8; k++) send(1'b1);
    checks++; if (match_count !== 8'd5) begin errors++; $display("FAIL sat_count8 got %0d exp 5", match_count); end
    checks++; if (match_count2 !== 2'd3) begin errors++; $display("FAIL sat_count2 got %0d exp 3", match_count2); end
    step(1'b1, 1'b1, 1'b0, 4'b0000, 1'b1, 1'b0);
    checks++; if (outp !== 1'b1) begin errors++; $display("FAIL clr_hit_outp got %b exp 1", outp); end
    checks++;
    if (match_count !== 8'd0 || match_count2 !== 2'd0) begin
      errors++; $display("FAIL clr_wins counts %0d/%0d exp 0/0", match_count, match_count2);
    end
  endtask

  task automatic test_rst_mid();
    do_reset();
    overlap = 1'b1;
    send(1'b1); send(1'b0); send(1'b1);
    do_reset();
    send(1'b1);
    checks++;
    if (outp !== 1'b0 || fill !== 3'd1) begin
      errors++; $display("FAIL rst_mid outp %b fill %0d exp outp 0 fill 1", outp, fill);
    end
    step(1'b0, 1'b0, 1'b1, 4'b0110, 1'b0, 1'b0);
    send(1'b0); send(1'b1);
    do_reset();
    send(1'b1); send(1'b0); send(1'b1); send(1'b1);
    checks++; if (outp !== 1'b1) begin errors++; $display("FAIL rst_pattern_revert outp got %b exp 1", outp); end
  endtask

  task automatic test_random();
    logic b, v, ld, cl, r;
    logic [3:0] p;
    do_reset();
    overlap = 1'b1;
    for (int n = 0; n < 800; n++) begin
      if ($urandom_range(0, 19) == 0) overlap = ~overlap;
      b  = logic'($urandom_range(0, 1));
      v  = ($urandom_range(0, 3) != 0);
      ld = ($urandom_range(0, 59) == 0);
      p  = 4'($urandom_range(0, 15));
      cl = ($urandom_range(0, 39) == 0);
      r  = ($urandom_range(0, 149) == 0);
      step(b, v, ld, p, cl, r);
      checks++;
      if (outp !== m_outp || outp2 !== m_outp) begin
        errors++; $display("FAIL rnd_outp cyc%0d got %b/%b exp %b", n, outp, outp2, m_outp);
      end
      checks++;
      if (fill !== 3'(hq.size()) || fill2 !== 3'(hq.size())) begin
        errors++; $display("FAIL rnd_fill cyc%0d got %0d/%0d exp %0d", n, fill, fill2, hq.size());
      end
      checks++;
      if (match_count !== 8'(m_cnt8) || match_count2 !== 2'(m_cnt2)) begin
        errors++; $display("FAIL rnd_count cyc%0d got %0d/%0d exp %0d/%0d", n, match_count, match_count2, m_cnt8, m_cnt2);
      end
    end
  endtask

  initial begin
    rst = 1'b1; inp = 1'b0; inp_valid = 1'b0; load = 1'b0; pat_in = '0;
    overlap = 1'b1; clear_count = 1'b0;
    m_pat = RST_PAT; m_outp = 1'b0; m_cnt8 = 0; m_cnt2 = 0;
    test_reset();
    test_overlap();
    test_non_overlap();
    test_idle();
    test_load();
    test_saturate();
    test_rst_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
